// File: rtl/ila_pkg.sv
// Shared encodings for the parametrised circular-buffer logic analyzer.
package ila_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARMED   = 3'd1;
  localparam logic [2:0] PRIMED  = 3'd2;
  localparam logic [2:0] HOLDOFF = 3'd3;
  localparam logic [2:0] STOPPED = 3'd4;
  localparam logic [2:0] READOUT = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = IDLE,
    ST_ARMED   = ARMED,
    ST_PRIMED  = PRIMED,
    ST_HOLDOFF = HOLDOFF,
    ST_STOPPED = STOPPED,
    ST_READOUT = READOUT
  } state_e;

  localparam logic [1:0] TRIG_LEVEL = 2'd0;
  localparam logic [1:0] TRIG_RISE  = 2'd1;
  localparam logic [1:0] TRIG_EXT   = 2'd2;

endpackage

// File: rtl/ila_trigger_unit.sv
// Masked compare, rising-edge detect and external strobe select; fire is combinational.
module ila_trigger_unit
  import ila_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_mode,
  input  logic [DATA_WIDTH-1:0] i_mask,
  input  logic [DATA_WIDTH-1:0] i_value,
  input  logic                  i_ext,
  output logic                  o_fire_c
);

  logic match_c;
  logic prev_match_q, prev_match_d;

  always_comb begin
    match_c      = ((i_data ^ i_value) & i_mask) == '0;
    prev_match_d = i_clear ? 1'b0 : match_c;
    o_fire_c     = 1'b0;
    case (i_mode)
      TRIG_LEVEL: o_fire_c = match_c;
      TRIG_RISE:  o_fire_c = match_c & ~prev_match_q;
      TRIG_EXT:   o_fire_c = i_ext;
      default:    o_fire_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) prev_match_q <= 1'b0;
    else       prev_match_q <= prev_match_d;
  end

endmodule

// File: rtl/ila_scope_param.sv
// Circular-buffer logic analyzer: arm, fill, trigger, holdoff, freeze, then oldest-first readout.
module ila_scope_param
  import ila_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned HOLDOFF_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_arm,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic [1:0]               i_trig_mode,
  input  logic [DATA_WIDTH-1:0]    i_trig_mask,
  input  logic [DATA_WIDTH-1:0]    i_trig_value,
  input  logic                     i_ext_trigger,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic                     i_rd_req,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_valid,
  output logic                     o_primed,
  output logic                     o_triggered,
  output logic                     o_stopped,
  output logic [ADDR_WIDTH-1:0]    o_trig_index,
  output logic                     o_trig_lost
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         fill_q, fill_d;
  logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic [HOLDOFF_WIDTH-1:0] hold_lat_q, hold_lat_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     primed_q, primed_d;
  logic                     triggered_q, triggered_d;
  logic                     stopped_q, stopped_d;
  logic [ADDR_WIDTH-1:0]    trig_index_q, trig_index_d;
  logic                     trig_lost_q, trig_lost_d;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic                     wr_en_c, arm_c, fire_c, go_stop_c;
  logic [HOLDOFF_WIDTH-1:0] stop_h_c;
  logic [ADDR_WIDTH-1:0]    rd_addr_c;

  ila_trigger_unit #(.DATA_WIDTH(DATA_WIDTH)) u_trig (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (arm_c),
    .i_data   (i_data),
    .i_mode   (i_trig_mode),
    .i_mask   (i_trig_mask),
    .i_value  (i_trig_value),
    .i_ext    (i_ext_trigger),
    .o_fire_c (fire_c)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    rd_cnt_d     = rd_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    hold_lat_d   = hold_lat_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    primed_d     = primed_q;
    triggered_d  = triggered_q;
    stopped_d    = stopped_q;
    trig_index_d = trig_index_q;
    trig_lost_d  = trig_lost_q;
    wr_en_c      = 1'b0;
    arm_c        = 1'b0;
    go_stop_c    = 1'b0;
    stop_h_c     = hold_lat_q;
    // Oldest entry sits at the write pointer once the buffer has wrapped.
    rd_addr_c    = wr_ptr_q + rd_cnt_q[ADDR_WIDTH-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (i_arm) begin
          state_d      = ST_ARMED;
          arm_c        = 1'b1;
          wr_ptr_d     = '0;
          fill_d       = '0;
          rd_cnt_d     = '0;
          hold_cnt_d   = '0;
          trig_index_d = '0;
          trig_lost_d  = 1'b0;
        end
      end
      ST_ARMED: begin
        wr_en_c = 1'b1;
        if (fill_q == CNT_W'(DEPTH - 1)) begin
          state_d  = ST_PRIMED;
          primed_d = 1'b1;
          fill_d   = CNT_W'(DEPTH);
        end else begin
          fill_d = fill_q + CNT_W'(1);
        end
      end
      ST_PRIMED: begin
        wr_en_c = 1'b1;
        if (fire_c) begin
          triggered_d = 1'b1;
          hold_lat_d  = i_holdoff;
          hold_cnt_d  = i_holdoff;
          if (i_holdoff == '0) begin
            go_stop_c = 1'b1;
            stop_h_c  = i_holdoff;
          end else begin
            state_d = ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        wr_en_c    = 1'b1;
        hold_cnt_d = hold_cnt_q - HOLDOFF_WIDTH'(1);
        if (hold_cnt_q == HOLDOFF_WIDTH'(1)) go_stop_c = 1'b1;
      end
      ST_STOPPED, ST_READOUT: begin
        if (i_rd_req) begin
          valid_d  = 1'b1;
          data_d   = mem_q[rd_addr_c];
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          state_d  = ST_READOUT;
          if (rd_cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d     = ST_IDLE;
            stopped_d   = 1'b0;
            primed_d    = 1'b0;
            triggered_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A holdoff of DEPTH or more has overwritten the trigger sample.
    if (go_stop_c) begin
      state_d   = ST_STOPPED;
      stopped_d = 1'b1;
      if (32'(stop_h_c) >= 32'(DEPTH)) begin
        trig_lost_d  = 1'b1;
        trig_index_d = '0;
      end else begin
        trig_index_d = ADDR_WIDTH'(DEPTH - 1) - ADDR_WIDTH'(stop_h_c);
      end
    end

    if (wr_en_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      rd_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      hold_lat_q   <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      primed_q     <= 1'b0;
      triggered_q  <= 1'b0;
      stopped_q    <= 1'b0;
      trig_index_q <= '0;
      trig_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      rd_cnt_q     <= rd_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_lat_q   <= hold_lat_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      primed_q     <= primed_d;
      triggered_q  <= triggered_d;
      stopped_q    <= stopped_d;
      trig_index_q <= trig_index_d;
      trig_lost_q  <= trig_lost_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_primed     = primed_q;
  assign o_triggered  = triggered_q;
  assign o_stopped    = stopped_q;
  assign o_trig_index = trig_index_q;
  assign o_trig_lost  = trig_lost_q;

endmodule
